// File: rtl/var_unshift.sv
// Variable-width bit-stream unpacker: accepts 32-bit words and emits
// right-justified fields of 0-32 bits, LSB-first or MSB-first.
module var_unshift #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         dir,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   shift,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] q,
  output logic [6:0]   level
);

  logic [63:0] buf_q, buf_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;

  logic [6:0]  eff_s;
  logic        push_s, pop_s, dir_use_s;
  logic [6:0]  pop_n_s, cnt_pop_s;
  logic [63:0] shifted_s, ins_s, field_s;

  // Requested widths above one word saturate to a full word.
  function automatic logic [6:0] sat_width(input logic [5:0] s);
    if (s > 6'd32) begin
      return 7'd32;
    end else begin
      return {1'b0, s};
    end
  endfunction

  function automatic logic [63:0] low_mask(input logic [6:0] n);
    return (64'd1 << n) - 64'd1;
  endfunction

  assign eff_s     = sat_width(shift);
  assign in_ready  = clr & en & (cnt_q <= 7'd32);
  assign out_valid = clr & en & (cnt_q >= eff_s);
  assign level     = cnt_q;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Field extraction from the head of the buffer in the latched order.
  always_comb begin
    field_s = 64'd0;
    if (!clr) begin
      field_s = 64'd0;
    end else if (dir_q) begin
      field_s = buf_q >> (7'd64 - eff_s);
    end else begin
      field_s = buf_q & low_mask(eff_s);
    end
  end

  assign q = field_s[W-1:0];

  // Pop first, then land the pushed word at the post-pop boundary. An empty
  // buffer adopts the incoming order immediately so the push lands correctly.
  always_comb begin
    pop_n_s   = 7'd0;
    cnt_pop_s = 7'd0;
    dir_use_s = dir_q;
    shifted_s = buf_q;
    ins_s     = 64'd0;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;

    pop_n_s   = pop_s ? eff_s : 7'd0;
    cnt_pop_s = cnt_q - pop_n_s;
    dir_use_s = (cnt_q == 7'd0) ? dir : dir_q;

    if (dir_use_s) begin
      shifted_s = buf_q << pop_n_s;
      ins_s     = {in, 32'd0} >> cnt_pop_s;
    end else begin
      shifted_s = buf_q >> pop_n_s;
      ins_s     = {32'd0, in} << cnt_pop_s;
    end

    if (push_s) begin
      buf_d = shifted_s | ins_s;
      cnt_d = cnt_pop_s + 7'd32;
    end else begin
      buf_d = shifted_s;
      cnt_d = cnt_pop_s;
    end

    if (en && (cnt_q == 7'd0)) begin
      dir_d = dir;
    end else begin
      dir_d = dir_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      buf_q <= 64'd0;
      cnt_q <= 7'd0;
      dir_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: tb/tb_var_unshift.sv
// Directed bench for var_unshift: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_var_unshift;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic        dir;
  logic [31:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  shift;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] q;
  logic [6:0]  level;

  int n_err   = 0;
  int n_check = 0;

  var_unshift #(.W(32)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .dir      (dir),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .shift    (shift),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .q        (q),
    .level    (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        dir;
    logic        iv;
    logic [31:0] din;
    logic [5:0]  sh;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_q;
    logic [6:0]  exp_lvl;
  } vec_t;

  vec_t vecs[41];

  function automatic vec_t mk(logic e, logic d, logic iv, logic [31:0] w, logic [5:0] sh,
                              logic ordy, logic ir, logic ov, logic [31:0] eq, logic [6:0] el);
    vec_t v;
    v.en = e; v.dir = d; v.iv = iv; v.din = w; v.sh = sh; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_q = eq; v.exp_lvl = el;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic ir, input logic ov,
                         input logic [31:0] eq, input logic [6:0] el);
    chk({tag, ".in_ready"},  idx, {31'd0, in_ready},  {31'd0, ir});
    chk({tag, ".out_valid"}, idx, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".q"},         idx, q, eq);
    chk({tag, ".level"},     idx, {25'd0, level},     {25'd0, el});
  endtask

  initial begin
    logic [31:0] nib[8];
    logic [31:0] byt[4];
    nib = '{32'hF, 32'hE, 32'hD, 32'hC, 32'hB, 32'hA, 32'h9, 32'h8};
    byt = '{32'h89, 32'hAB, 32'hCD, 32'hEF};

    // LSB-first nibbles
    vecs[0] = mk(1'b1, 1'b0, 1'b1, 32'h89ABCDEF, 6'd4, 1'b1, 1'b1, 1'b0, 32'h0, 7'd0);
    for (int k = 0; k < 8; k++)
      vecs[1+k] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd4, 1'b1, 1'b1, 1'b1, nib[k], 7'(32 - 4*k));
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd4, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    // MSB-first bytes
    vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h89ABCDEF, 6'd8, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    for (int k = 0; k < 4; k++)
      vecs[11+k] = mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd8, 1'b1, 1'b1, 1'b1, byt[k], 7'(32 - 8*k));
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd8, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    // Straddle and saturated width
    vecs[16] = mk(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 6'd20, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 32'h00000000, 6'd20, 1'b0, 1'b1, 1'b1, 32'hFFFFF, 7'd32);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd20, 1'b1, 1'b0, 1'b1, 32'hFFFFF, 7'd64);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd20, 1'b1, 1'b0, 1'b1, 32'h00FFF, 7'd44);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd20, 1'b1, 1'b1, 1'b1, 32'h00000, 7'd24);
    vecs[21] = mk(1'b1, 1'b0, 1'b1, 32'h12345678, 6'd40, 1'b0, 1'b1, 1'b0, 32'h0, 7'd4);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd40, 1'b1, 1'b0, 1'b1, 32'h23456780, 7'd36);
    vecs[23] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd4, 1'b1, 1'b1, 1'b1, 32'h1, 7'd4);
    // Full and back-pressure
    vecs[24] = mk(1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 6'd4, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    vecs[25] = mk(1'b1, 1'b0, 1'b1, 32'h55555555, 6'd4, 1'b0, 1'b1, 1'b1, 32'hA, 7'd32);
    vecs[26] = mk(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 6'd4, 1'b0, 1'b0, 1'b1, 32'hA, 7'd64);
    vecs[27] = mk(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 6'd4, 1'b1, 1'b0, 1'b1, 32'hA, 7'd64);
    vecs[28] = mk(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 6'd4, 1'b0, 1'b0, 1'b1, 32'hA, 7'd60);
    vecs[29] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd28, 1'b1, 1'b0, 1'b1, 32'h0AAAAAAA, 7'd60);
    vecs[30] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd32, 1'b0, 1'b1, 1'b1, 32'h55555555, 7'd32);
    // Concurrent push and pop at level 32
    vecs[31] = mk(1'b1, 1'b0, 1'b1, 32'hA0A0A0A0, 6'd32, 1'b1, 1'b1, 1'b1, 32'h55555555, 7'd32);
    vecs[32] = mk(1'b1, 1'b0, 1'b1, 32'hB1B1B1B1, 6'd32, 1'b1, 1'b1, 1'b1, 32'hA0A0A0A0, 7'd32);
    vecs[33] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd32, 1'b1, 1'b1, 1'b1, 32'hB1B1B1B1, 7'd32);
    // Zero-width field: always valid, consumes nothing
    vecs[34] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 1'b1, 1'b1, 1'b1, 32'h0, 7'd0);
    vecs[35] = mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd4, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    // Build level 40, then hold it with en low; dir changes must be ignored
    vecs[36] = mk(1'b1, 1'b0, 1'b1, 32'h000000FF, 6'd8, 1'b0, 1'b1, 1'b0, 32'h0, 7'd0);
    vecs[37] = mk(1'b1, 1'b0, 1'b1, 32'h12345678, 6'd24, 1'b1, 1'b1, 1'b1, 32'h0000FF, 7'd32);
    vecs[38] = mk(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 6'd16, 1'b1, 1'b0, 1'b0, 32'h7800, 7'd40);
    vecs[39] = mk(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 6'd16, 1'b1, 1'b0, 1'b0, 32'h7800, 7'd40);
    vecs[40] = mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd16, 1'b1, 1'b0, 1'b1, 32'h7800, 7'd40);

    clr = 1'b0; en = 1'b1; dir = 1'b0; din = 32'h0;
    in_valid = 1'b0; shift = 6'd4; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all("reset", 0, 1'b0, 1'b0, 32'h0, 7'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk({"release", ".in_ready"}, 0, {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      en = vecs[i].en; dir = vecs[i].dir; in_valid = vecs[i].iv;
      din = vecs[i].din; shift = vecs[i].sh; out_ready = vecs[i].ordy;
      #1;
      chk_all("vec", i, vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_q, vecs[i].exp_lvl);
    end

    // Asynchronous clear mid-cycle at level 24 discards everything at once
    @(negedge clk);
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; shift = 6'd8;
    #1;
    chk({"pre_clr", ".level"}, 0, {25'd0, level}, 32'd24);
    #1;
    clr = 1'b0;
    #1;
    chk_all("mid_clr", 0, 1'b0, 1'b0, 32'h0, 7'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_clr", 0, 1'b1, 1'b0, 32'h0, 7'd0);

    // Operation resumes after the clear
    @(negedge clk);
    in_valid = 1'b1; din = 32'hCAFEF00D; shift = 6'd32;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_all("resume", 0, 1'b1, 1'b1, 32'hCAFEF00D, 7'd32);

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule

// File: doc/var_unshift.md
# var_unshift

Variable-width bit-stream unpacker: the reader-side counterpart of the team's variable shift register. It accepts 32-bit words on a valid/ready input and emits right-justified fields of 0–32 bits, with width selected per transfer by `shift`. Fields are extracted LSB-first or MSB-first, and may straddle word boundaries. It sits downstream of packed-stream sources in the shifter datapath, for example to unpack headers or variable-length fields.

## Interface
- `W`, 32, word width; fixed at 32 for this revision.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  asynchronous, active-low reset.
- `en`  in  1  enable; when 0, all state holds and both handshakes are blocked.
- `dir`  in  1  extraction order: 0 = LSB-first (right shift out), 1 = MSB-first (left shift out).
- `in`  in  32  input word.
- `in_valid`  in  1  `in` is valid.
- `in_ready`  out  1  the block accepts `in` this cycle.
- `shift`  in  6  requested field width; values 33–63 saturate to 32 (effective width `eff`).
- `out_ready`  in  1  the consumer takes `q` this cycle.
- `out_valid`  out  1  `q` holds a complete field of `eff` bits.
- `q`  out  32  extracted field, right-justified, upper bits zero.
- `level`  out  7  bits held in the buffer (0–64).

## Operation
- State:
  - 64-bit buffer `buf`.
  - Bit count `cnt`, 0–64; drives `level`.
  - Latched order `dir_q`.
- `dir_q` loads `dir` on every clock edge where `cnt == 0`; otherwise `dir` is ignored.
- `in_ready = clr & en & (cnt <= 32)`, computed from registered `cnt`.
- `out_valid = clr & en & (cnt >= eff)`.
- Push: `in_valid & in_ready`.
- Pop: `out_valid & out_ready`.
- Let `pop_n = pop ? eff : 0` and `cnt' = cnt - pop_n`.
- Next-state count: `cnt_next = cnt' + (push ? 32 : 0)`.
- LSB-first (`dir_q = 0`):
  - Valid bits sit at `buf[cnt-1:0]`.
  - `q = buf[eff-1:0]`.
  - Pop shifts `buf` right by `eff`.
  - Push ORs `in << cnt'` into the shifted buffer.
- MSB-first (`dir_q = 1`):
  - Valid bits sit at `buf[63:64-cnt]`.
  - `q = buf[63:64-eff]`.
  - Pop shifts `buf` left by `eff`.
  - Push ORs `(in << 32) >> cnt'` into the shifted buffer.
- Push and pop in the same cycle are legal. The pop is applied first, then the push lands at the post-pop boundary.
- `eff = 0`: `out_valid = en` and `q = 0`; the pop consumes nothing.
- Bits beyond `cnt` in `buf` are kept at zero at all times.
- `en = 0`: `buf`, `cnt` and `dir_q` hold. `in_ready = 0` and `out_valid = 0`; `q` still reflects `buf`.

## Timing
- Reset (`clr = 0`) clears `buf`, `cnt` (`level = 0`) and `dir_q`, asynchronously and immediately.
- While `clr = 0`, `in_ready = 0`, `out_valid = 0` and `q = 0`.
- First rising edge after release: `in_ready = 1` if `en = 1`.
- `q`, `out_valid` and `in_ready` are combinational from registered state plus `shift` and `en`. No output depends combinationally on `in_valid` or `out_ready`.
- Latency: a word accepted at edge N makes a field available at or after edge N+1, meaning `out_valid` is high in the cycle following the push.
- Throughput:
  - One push and one pop per cycle.
  - Sustained 32 bits/cycle at `eff = 32` with `cnt = 32`.
- Full condition: at `cnt > 32`, `in_ready = 0` even if a pop occurs in the same cycle. There is no combinational bypass.
- Empty condition: at `cnt < eff`, `out_valid = 0` until enough words arrive. A changed `shift` is re-evaluated in the same cycle.
- Reset mid-operation discards all buffered bits. There is no partial output.

## Test plan
- LSB-first nibbles: `dir = 0`, push `0x89ABCDEF`, `shift = 4`, `out_ready = 1`.
  - Response: `q = 0xF, 0xE, 0xD, 0xC, 0xB, 0xA, 0x9, 0x8` on consecutive cycles.
  - Then `out_valid = 0` and `level = 0`.
- MSB-first bytes: `dir = 1`, push `0x89ABCDEF`, `shift = 8`.
  - Response: `q = 0x89, 0xAB, 0xCD, 0xEF`.
  - `level` steps 32 → 24 → 16 → 8 → 0.
- Straddle: `dir = 0`, push `0xFFFFFFFF` then `0x00000000`, `shift = 20`.
  - Response: `q = 0xFFFFF`, then `0x00FFF`, then `0x00000`.
  - Final `level = 4`.
  - `shift = 40` behaves as 32.
- Full and back-pressure: push three words with `out_ready = 0`.
  - Response: two words accepted, `level = 64`, `in_ready = 0`.
  - Pop `shift = 4` → `level = 60`, `in_ready` still 0.
  - Pop down to `level = 32` → `in_ready = 1`.
- Concurrent push and pop at `level = 32`, `shift = 32`, words A then B.
  - Response: `level` stays 32.
  - `q = A` in one cycle, then `q = B` in the next.
- Enable and reset:
  - `en = 0` at `level = 40`: `level` holds at 40, `in_ready = out_valid = 0`.
  - Drop `clr` mid-cycle: `level = 0` and `out_valid = 0` immediately, before any clock edge.
  - Release `clr` with `en = 1`: `in_ready = 1` after the first edge.
